sub_vech_detect: RTL and testbench

Upstream conditioning stage for the traffic signal controller (sig_control). It takes the raw sub-road loop-detector input, synchronises and debounces it, and counts waiting vehicles. It drains the count while the sub road shows GREEN, and drives the VECH_AT_SUB_SIG request consumed by sig_control. A stuck-sensor fault forces the request high so the sub road is never starved.

---
 rtl/sub_vech_detect.sv | 182 ++++++++++++++++++
 tb/tb_sub_vech_detect.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sub_vech_detect.sv
// Sub-road vehicle detector: synchronises and debounces the loop sensor, counts waiting
// vehicles, drains them on sub-road GREEN and raises the request for sig_control.
module sub_vech_detect #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 4,
  parameter int DEPART_CYCLES   = 6,
  parameter int STUCK_CYCLES    = 64
) (
  input  logic             CLOCK,
  input  logic             CLEAR,
  input  logic             SENSOR_RAW,
  input  logic [1:0]       SUB_SIG,
  output logic             VECH_AT_SUB_SIG,
  output logic [CNT_W-1:0] VECH_COUNT,
  output logic             VECH_EVENT,
  output logic             OVERFLOW,
  output logic             FAULT
);

  localparam int DEB_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int DEP_W = $clog2(DEPART_CYCLES) + 1;
  localparam int ST_W  = $clog2(STUCK_CYCLES) + 1;

  localparam logic [DEB_W-1:0] DEB_MAX  = DEB_W'(DEBOUNCE_CYCLES);
  localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1'b1);
  localparam logic [DEP_W-1:0] DEP_LAST = DEP_W'(DEPART_CYCLES - 1);
  localparam logic [DEP_W-1:0] DEP_ONE  = DEP_W'(1'b1);
  localparam logic [ST_W-1:0]  ST_MAX   = ST_W'(STUCK_CYCLES);
  localparam logic [ST_W-1:0]  ST_ONE   = ST_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    STUCK   = 2'd2
  } state_t;

  logic             sync1_r, sync2_r, filt_r;
  logic [DEB_W-1:0] deb_cnt_r;
  state_t           state_r;
  logic [ST_W-1:0]  stuck_cnt_r;
  logic [DEP_W-1:0] dis_cnt_r;
  logic [CNT_W-1:0] count_r;
  logic             event_r, ovf_r, fault_r, req_r;

  logic             arrival_s, stuck_hit_s, fault_nxt_s;
  logic             green_s, depart_s, ovf_nxt_s, req_nxt_s;
  logic [DEP_W-1:0] dis_nxt_s;
  logic [CNT_W-1:0] count_nxt_s;

  // Two-flop synchroniser followed by the disagreement-counting debounce filter
  always_ff @(posedge CLOCK or negedge CLEAR) begin
    if (!CLEAR) begin
      sync1_r   <= 1'b0;
      sync2_r   <= 1'b0;
      filt_r    <= 1'b0;
      deb_cnt_r <= '0;
    end else begin
      sync1_r <= SENSOR_RAW;
      sync2_r <= sync1_r;
      if (sync2_r == filt_r) begin
        deb_cnt_r <= '0;
      end else if (deb_cnt_r + DEB_ONE == DEB_MAX) begin
        filt_r    <= ~filt_r;
        deb_cnt_r <= '0;
      end else begin
        deb_cnt_r <= deb_cnt_r + DEB_ONE;
      end
    end
  end

  // Sensor FSM decode: arrival on IDLE->PRESENT, fault held for the whole STUCK period
  always_comb begin
    arrival_s   = (state_r == IDLE) && filt_r;
    stuck_hit_s = (state_r == PRESENT) && filt_r && (stuck_cnt_r + ST_ONE == ST_MAX);
    case (state_r)
      STUCK:   fault_nxt_s = filt_r;
      PRESENT: fault_nxt_s = stuck_hit_s;
      default: fault_nxt_s = 1'b0;
    endcase
  end

  // Sensor FSM with stuck counter and registered event/fault outputs
  always_ff @(posedge CLOCK or negedge CLEAR) begin
    if (!CLEAR) begin
      state_r     <= IDLE;
      stuck_cnt_r <= '0;
      event_r     <= 1'b0;
      fault_r     <= 1'b0;
    end else begin
      event_r <= arrival_s;
      fault_r <= fault_nxt_s;
      case (state_r)
        IDLE: begin
          stuck_cnt_r <= '0;
          if (filt_r) begin
            state_r <= PRESENT;
          end else begin
            state_r <= IDLE;
          end
        end
        PRESENT: begin
          if (!filt_r) begin
            state_r     <= IDLE;
            stuck_cnt_r <= '0;
          end else if (stuck_hit_s) begin
            state_r     <= STUCK;
            stuck_cnt_r <= '0;
          end else begin
            stuck_cnt_r <= stuck_cnt_r + ST_ONE;
          end
        end
        STUCK: begin
          stuck_cnt_r <= '0;
          if (!filt_r) begin
            state_r <= IDLE;
          end else begin
            state_r <= STUCK;
          end
        end
        default: begin
          state_r     <= IDLE;
          stuck_cnt_r <= '0;
        end
      endcase
    end
  end

  // Discharge timer and waiting-count update; arrival and departure on one edge cancel out
  always_comb begin
    green_s     = (SUB_SIG == 2'd2);
    depart_s    = 1'b0;
    dis_nxt_s   = '0;
    count_nxt_s = count_r;
    ovf_nxt_s   = ovf_r;
    if (green_s && (count_r != '0)) begin
      if (dis_cnt_r == DEP_LAST) begin
        dis_nxt_s = '0;
        depart_s  = 1'b1;
      end else begin
        dis_nxt_s = dis_cnt_r + DEP_ONE;
      end
    end else begin
      dis_nxt_s = '0;
    end
    if (arrival_s && !depart_s) begin
      if (count_r == CNT_MAX) begin
        ovf_nxt_s = 1'b1;
      end else begin
        count_nxt_s = count_r + CNT_ONE;
      end
    end else if (depart_s && !arrival_s) begin
      count_nxt_s = count_r - CNT_ONE;
    end else begin
      count_nxt_s = count_r;
    end
    req_nxt_s = (count_nxt_s != '0) || fault_nxt_s;
  end

  // Count, overflow, discharge timer and request registers
  always_ff @(posedge CLOCK or negedge CLEAR) begin
    if (!CLEAR) begin
      dis_cnt_r <= '0;
      count_r   <= '0;
      ovf_r     <= 1'b0;
      req_r     <= 1'b0;
    end else begin
      dis_cnt_r <= dis_nxt_s;
      count_r   <= count_nxt_s;
      ovf_r     <= ovf_nxt_s;
      req_r     <= req_nxt_s;
    end
  end

  assign VECH_AT_SUB_SIG = req_r;
  assign VECH_COUNT      = count_r;
  assign VECH_EVENT      = event_r;
  assign OVERFLOW        = ovf_r;
  assign FAULT           = fault_r;

endmodule

// File: tb/tb_sub_vech_detect.sv
// Bench for sub_vech_detect: arrivals push expected results into a scoreboard that a
// negedge monitor drains on every VECH_EVENT; directed checks cover timing and fault paths.
module tb_sub_vech_detect;

  logic       CLOCK;
  logic       CLEAR;
  logic       SENSOR_RAW;
  logic [1:0] SUB_SIG;
  logic       VECH_AT_SUB_SIG;
  logic [3:0] VECH_COUNT;
  logic       VECH_EVENT;
  logic       OVERFLOW;
  logic       FAULT;

  typedef struct packed {
    logic [3:0] cnt;
    logic       ovf;
    logic       req;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_bad   = 0;

  sub_vech_detect dut (
    .CLOCK           (CLOCK),
    .CLEAR           (CLEAR),
    .SENSOR_RAW      (SENSOR_RAW),
    .SUB_SIG         (SUB_SIG),
    .VECH_AT_SUB_SIG (VECH_AT_SUB_SIG),
    .VECH_COUNT      (VECH_COUNT),
    .VECH_EVENT      (VECH_EVENT),
    .OVERFLOW        (OVERFLOW),
    .FAULT           (FAULT)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic tick(input int n);
    repeat (n) @(posedge CLOCK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    CLEAR      = 1'b0;
    SENSOR_RAW = 1'b0;
    SUB_SIG    = 2'd0;
    tick(3);
    CLEAR = 1'b1;
    tick(1);
  endtask

  // One clean vehicle: sensor high 8 samples, then low long enough for the FSM to return to IDLE
  task automatic arrive(input logic [3:0] cnt, input logic ovf, input logic req);
    exp_t e;
    e.cnt = cnt;
    e.ovf = ovf;
    e.req = req;
    exp_q.push_back(e);
    SENSOR_RAW = 1'b1;
    tick(8);
    SENSOR_RAW = 1'b0;
    tick(8);
  endtask

  // Monitor: every event cycle must match the next scoreboard entry
  always @(negedge CLOCK) begin
    if (CLEAR && VECH_EVENT) begin
      n_total++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_event count=%0d", VECH_COUNT);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({VECH_COUNT, OVERFLOW, VECH_AT_SUB_SIG} !== {e.cnt, e.ovf, e.req}) begin
          n_bad++;
          $display("FAIL event_result actual cnt=%0d ovf=%0d req=%0d expected cnt=%0d ovf=%0d req=%0d",
                   VECH_COUNT, OVERFLOW, VECH_AT_SUB_SIG, e.cnt, e.ovf, e.req);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    CLEAR      = 1'b0;
    SENSOR_RAW = 1'b0;
    SUB_SIG    = 2'd0;
    do_reset();
    chk("reset_outputs", {27'd0, VECH_AT_SUB_SIG, VECH_COUNT, VECH_EVENT, OVERFLOW, FAULT}, 32'd0);

    // 1: single arrival, exact latency
    exp_q.push_back('{cnt: 4'd1, ovf: 1'b0, req: 1'b1});
    SENSOR_RAW = 1'b1;
    tick(6);
    chk("t1_no_event_at_5", VECH_EVENT, 0);
    chk("t1_count_at_5", VECH_COUNT, 0);
    tick(1);
    chk("t1_event_at_6", VECH_EVENT, 1);
    chk("t1_count", VECH_COUNT, 1);
    chk("t1_req", VECH_AT_SUB_SIG, 1);
    tick(3);
    SENSOR_RAW = 1'b0;
    tick(10);
    chk("t1_count_after", VECH_COUNT, 1);

    // 2: three-cycle glitch is filtered out
    do_reset();
    SENSOR_RAW = 1'b1;
    tick(3);
    SENSOR_RAW = 1'b0;
    tick(12);
    chk("t2_count", VECH_COUNT, 0);
    chk("t2_req", VECH_AT_SUB_SIG, 0);

    // 3: discharge on GREEN, interrupted progress restarts
    do_reset();
    arrive(4'd1, 1'b0, 1'b1);
    arrive(4'd2, 1'b0, 1'b1);
    arrive(4'd3, 1'b0, 1'b1);
    SUB_SIG = 2'd2;
    tick(5);
    chk("t3_count_3_hold", VECH_COUNT, 3);
    tick(1);
    chk("t3_count_2", VECH_COUNT, 2);
    tick(6);
    chk("t3_count_1", VECH_COUNT, 1);
    tick(4);
    SUB_SIG = 2'd3;
    tick(3);
    chk("t3_illegal_not_green", VECH_COUNT, 1);
    SUB_SIG = 2'd2;
    tick(5);
    chk("t3_restart_hold", VECH_COUNT, 1);
    chk("t3_req_hold", VECH_AT_SUB_SIG, 1);
    tick(1);
    chk("t3_count_0", VECH_COUNT, 0);
    chk("t3_req_fall", VECH_AT_SUB_SIG, 0);
    tick(8);
    chk("t3_floor_0", VECH_COUNT, 0);
    SUB_SIG = 2'd0;

    // 4: saturation and sticky overflow
    do_reset();
    for (int i = 0; i < 16; i++) begin
      arrive((i < 15) ? 4'(i + 1) : 4'd15, (i == 15), 1'b1);
      if (i == 14) chk("t4_no_ovf_at_15", OVERFLOW, 0);
    end
    chk("t4_count_sat", VECH_COUNT, 15);
    chk("t4_ovf", OVERFLOW, 1);

    // 5: arrival on the same edge as a departure
    do_reset();
    arrive(4'd1, 1'b0, 1'b1);
    arrive(4'd2, 1'b0, 1'b1);
    exp_q.push_back('{cnt: 4'd2, ovf: 1'b0, req: 1'b1});
    SENSOR_RAW = 1'b1;
    tick(1);
    SUB_SIG = 2'd2;
    tick(5);
    chk("t5_count_before", VECH_COUNT, 2);
    tick(1);
    chk("t5_event", VECH_EVENT, 1);
    chk("t5_count_same", VECH_COUNT, 2);
    chk("t5_ovf", OVERFLOW, 0);
    SUB_SIG = 2'd0;
    tick(2);
    SENSOR_RAW = 1'b0;
    tick(10);

    // 6: stuck sensor, request held with empty count, then async clear mid-STUCK
    do_reset();
    exp_q.push_back('{cnt: 4'd1, ovf: 1'b0, req: 1'b1});
    SENSOR_RAW = 1'b1;
    tick(7);
    SUB_SIG = 2'd2;
    tick(53);
    chk("t6_no_fault_early", FAULT, 0);
    chk("t6_drained", VECH_COUNT, 0);
    tick(16);
    chk("t6_fault", FAULT, 1);
    chk("t6_req_fault", VECH_AT_SUB_SIG, 1);
    chk("t6_count_zero", VECH_COUNT, 0);
    tick(4);
    SENSOR_RAW = 1'b0;
    tick(10);
    chk("t6_fault_clear", FAULT, 0);
    chk("t6_req_clear", VECH_AT_SUB_SIG, 0);
    SUB_SIG = 2'd0;
    exp_q.push_back('{cnt: 4'd1, ovf: 1'b0, req: 1'b1});
    SENSOR_RAW = 1'b1;
    tick(80);
    chk("t6_fault_again", FAULT, 1);
    #3;
    CLEAR = 1'b0;
    #1;
    chk("t6_async_clear", {27'd0, VECH_AT_SUB_SIG, VECH_COUNT, VECH_EVENT, OVERFLOW, FAULT}, 32'd0);
    SENSOR_RAW = 1'b0;
    tick(2);
    CLEAR = 1'b1;
    tick(3);
    chk("t6_after_release", {27'd0, VECH_AT_SUB_SIG, VECH_COUNT, VECH_EVENT, OVERFLOW, FAULT}, 32'd0);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
